gearbox_32_to_128: RTL
======================

// Module: gearbox_32_to_128
// PURPOSE
//  Width packer, ingress direction: assembles 32-bit AXI-Stream-style beats from the DMA read
//  channel into 128-bit words for the crypto input FIFO. Inverse of the 128->32 egress unpacker.
//  Lane order matches it: first beat lands in [31:0], fourth in [127:96]. Short tails
//  (tlast or flush with 1-3 beats) are zero-padded, and the valid 32-bit lanes are flagged.
// PARAMETERS
//  PAD_WORD   32'h0000_0000   fill value for unused lanes of a short final word
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    reset, asynchronous, active-low
//  s_data     in   32   upstream beat (DMA)
//  s_valid    in   1    upstream beat valid
//  s_last     in   1    last beat of packet, qualified by s_valid
//  s_ready    out  1    beat accepted when s_valid && s_ready
//  flush      in   1    1-cycle pulse: emit the partially filled word now (DMA timeout path)
//  m_data     out  128  packed word to FIFO
//  m_keep     out  16   byte keep, in 4-bit groups per lane; lane k valid -> m_keep[4k+3:4k]=4'hF
//  m_last     out  1    word contains a s_last beat
//  m_valid    out  1    packed word valid
//  m_ready    in   1    FIFO not full (write enable = m_valid && m_ready)
//  fill_cnt   out  2    lanes currently held in the accumulator (0..3), status/debug
// BEHAVIOUR
//  - State: acc[127:0], cnt[1:0] (lanes filled); output register {m_data, m_keep, m_last, m_valid}.
//  - Reset (async): acc=0, cnt=0, m_data=0, m_keep=0, m_last=0, m_valid=0.
//    s_ready=1 while in reset (comb., because m_valid=0).
//  - s_ready = !m_valid || m_ready (combinational). No other back-pressure source.
//    Full rate of 1 beat/clk while m_ready=1.
//  - Accepted beat: written to lane cnt. Emit condition E = (cnt==3) || s_last.
//    No E: cnt <= cnt+1, and the beat goes into acc.
//    E: output register <= {acc with beat in lane cnt, lanes >cnt = PAD_WORD}.
//    m_keep = lanes 0..cnt set. m_last = s_last. m_valid <= 1. cnt <= 0, and acc is cleared to 0.
//  - Latency: the completing beat is accepted at edge N. m_valid=1 is visible after edge N,
//    so the word can be written at edge N+1.
//  - Output hold: m_data, m_keep and m_last are stable while m_valid && !m_ready.
//    m_valid drops after a handshake unless a new word loads at the same edge (back-to-back).
//  - flush (takes effect only when s_ready=1):
//    cnt>0 and no beat accepted: emit acc, m_keep = lanes 0..cnt-1, m_last=0, then cnt <= 0.
//    flush with an accepted beat: the beat is packed first. If E holds, there is one emit only.
//    Otherwise the emit includes the new lane (keep lanes 0..cnt), m_last=0.
//    flush with cnt==0 and no beat: no-op (no empty words are ever produced).
//    flush while s_ready=0: ignored. The caller re-pulses.
//  - s_last with cnt==3: one full word, m_keep=16'hFFFF, m_last=1.
//  - s_valid=1 with s_ready=0: beat not consumed. Upstream holds it (AXI rule). No state change.
//  - Reset mid-packet: partial acc is discarded. No word is emitted for it.
//  - s_data, s_last and flush are ignored during reset.
// TESTING
//  1 Reset: assert rst_n=0 mid-packet (cnt=2) -> m_valid=0, fill_cnt=0, s_ready=1. The next packet
//    starts at lane 0.
//  2 Full word: beats 32'h11111111..44444444 with m_ready=1 -> m_data=128'h44444444_33333333_
//    22222222_11111111, m_keep=16'hFFFF, m_last=0, m_valid 1 clk after the 4th accept.
//  3 Short tail: beats A5A5A5A5, 5A5A5A5A (last) -> m_data=128'h0..0_5A5A5A5A_A5A5A5A5,
//    m_keep=16'h00FF, m_last=1.
//  4 Back-pressure: m_ready=0 with a word pending -> s_ready=0, output held for 10 clks.
//    Release -> 12 streamed beats give 3 words, in order, none lost or duplicated.
//  5 Flush: 3 beats, then a flush pulse -> m_keep=16'h0FFF, m_last=0. A flush at cnt=0 -> no word.
//    Flush with a 2nd beat -> keep=16'h00FF.
//  6 Round trip: random 128-bit words -> this block -> 128->32 unpacker with random ready.
//    Output equals input, bit-exact, for 1000 words.

Source files
------------

// File: rtl/gearbox_32_to_128.sv
// Packs 32-bit stream beats into 128-bit words; beat 0 in [31:0], beat 3 in [127:96]; short tails are padded and lane-flagged via m_keep.
// Latency: the word is visible on m_* one clock after its completing beat (or flush) is accepted.
// Backpressure: s_ready = !m_valid || m_ready; a pending word holds m_* stable and stalls the input.
module gearbox_32_to_128 #(
  parameter logic [31:0] PAD_WORD = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  input  logic         flush,
  output logic [127:0] m_data,
  output logic [15:0]  m_keep,
  output logic         m_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [1:0]   fill_cnt
);

  logic [127:0] acc;       // lanes collected so far; lanes >= cnt are kept at zero
  logic [1:0]   cnt;       // number of lanes held in acc
  logic         accept;    // beat handshake this cycle
  logic         flush_eff; // flush pulse that is honoured this cycle
  logic         emit;      // this cycle closes a word into the output register
  logic [2:0]   n_lanes;   // valid lanes in the word being closed
  logic [127:0] word_nxt;
  logic [15:0]  keep_nxt;

  // The output register is the only stall point: free or draining means ready.
  assign s_ready   = !m_valid || m_ready;
  assign accept    = s_valid && s_ready;
  assign flush_eff = flush && s_ready;
  assign fill_cnt  = cnt;
  assign n_lanes   = {1'b0, cnt} + {2'b00, accept};

  // Close a word on the 4th lane, on a last beat, or on flush; an empty flush is dropped.
  always_comb begin
    emit = 1'b0;
    if (accept) begin
      emit = (cnt == 2'd3) || s_last || flush_eff;
    end else begin
      emit = flush_eff && (cnt != 2'd0);
    end
  end

  // Candidate output word: held lanes, then the incoming beat, then padding above.
  always_comb begin
    word_nxt = '0;
    keep_nxt = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < {1'b0, cnt}) begin
        word_nxt[32*k +: 32] = acc[32*k +: 32];
      end else if ((3'(k) == {1'b0, cnt}) && accept) begin
        word_nxt[32*k +: 32] = s_data;
      end else begin
        word_nxt[32*k +: 32] = PAD_WORD;
      end
      keep_nxt[4*k +: 4] = (3'(k) < n_lanes) ? 4'hF : 4'h0;
    end
  end

  // Accumulator: collect beats lane by lane; a closed word restarts at lane 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= 2'd0;
    end else if (emit) begin
      acc <= '0;
      cnt <= 2'd0;
    end else if (accept) begin
      acc[{cnt, 5'd0} +: 32] <= s_data;
      cnt                    <= cnt + 2'd1;
    end
  end

  // Output register: load a closed word, otherwise hold until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end else if (emit) begin
      m_data  <= word_nxt;
      m_keep  <= keep_nxt;
      m_last  <= accept && s_last;
      m_valid <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
